// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory bridge: funct3 width codes, the
// bridge FSM state type, and helpers that derive byte strobes and detect
// requests the bridge refuses to issue (misaligned or illegal width).
package dmem_pkg;

    // funct3 access width codes as seen by the MEM stage
    localparam logic [2:0] W_B   = 3'b000;
    localparam logic [2:0] W_H   = 3'b001;
    localparam logic [2:0] W_W   = 3'b010;
    localparam logic [2:0] W_D   = 3'b011;
    localparam logic [2:0] W_BU  = 3'b100;
    localparam logic [2:0] W_HU  = 3'b101;
    localparam logic [2:0] W_WU  = 3'b110;
    localparam logic [2:0] W_ILL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } dmem_state_e;

    // Byte strobes for an access of the given width starting at byte lane.
    function automatic logic [7:0] strobe_for(input logic [2:0] width,
                                              input logic [2:0] lane);
        logic [7:0] s;
        case (width)
            W_B, W_BU: s = 8'h01 << lane;
            W_H, W_HU: s = 8'h03 << lane;
            W_W, W_WU: s = 8'h0F << lane;
            W_D:       s = 8'hFF;
            default:   s = 8'h00;
        endcase
        return s;
    endfunction

    // True when the request must be rejected: the access crosses its natural
    // alignment, or the width code is the reserved one.
    function automatic logic is_misaligned(input logic [2:0] width,
                                           input logic [2:0] lane);
        logic bad;
        case (width)
            W_H, W_HU: bad = lane[0];
            W_W, W_WU: bad = (lane[1:0] != 2'b00);
            W_D:       bad = (lane != 3'b000);
            W_ILL:     bad = 1'b1;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// load_formatter
// Combinational load-data formatter. Moves the addressed lane of the 64-bit
// bus word down to bit 0, truncates to the access width and sign- or
// zero-extends (b/h/w signed, bu/hu/wu/d unsigned).
// Ports:
//   bus_rdata  in  64  raw bus read word
//   lane       in  3   byte offset of the access inside the word
//   width      in  3   funct3 width code
//   load_data  out 64  formatted load value
module load_formatter
    import dmem_pkg::*;
(
    input  logic [63:0] bus_rdata,
    input  logic [2:0]  lane,
    input  logic [2:0]  width,
    output logic [63:0] load_data
);

    logic [63:0] shifted;

    always_comb begin
        shifted   = bus_rdata >> {lane, 3'b000};
        load_data = shifted;
        case (width)
            W_B:     load_data = {{56{shifted[7]}},  shifted[7:0]};
            W_H:     load_data = {{48{shifted[15]}}, shifted[15:0]};
            W_W:     load_data = {{32{shifted[31]}}, shifted[31:0]};
            W_BU:    load_data = {56'd0, shifted[7:0]};
            W_HU:    load_data = {48'd0, shifted[15:0]};
            W_WU:    load_data = {32'd0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge
// Bridge between the MEM stage and a variable-latency 64-bit memory bus.
// A legal request is latched in IDLE, issued as one aligned bus transaction
// (REQ), completed by the bus response (WAIT), and released to the pipeline
// for exactly one cycle (DONE). The pipeline is held through stall_out.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_read, mem_write              MEM-stage request strobes (write wins)
//   addr_in, wdata_in, width_in      byte address, right-aligned store data, funct3
//   rdata_out                        formatted load data (registered)
//   stall_out                        pipeline hold (combinational)
//   misalign_err, bus_err            one-cycle error pulses
//   bus_req_valid/bus_req_ready      bus request handshake
//   bus_addr, bus_we, bus_wstrb,
//   bus_wdata                        latched bus request fields
//   bus_resp_valid, bus_rdata        bus response
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] addr_in,
    input  logic [63:0] wdata_in,
    input  logic [2:0]  width_in,
    output logic [63:0] rdata_out,
    output logic        stall_out,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [63:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_wstrb,
    output logic [63:0] bus_wdata,
    input  logic        bus_resp_valid,
    input  logic [63:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    dmem_state_e      state;
    logic [2:0]       width_q;
    logic [2:0]       lane_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic [63:0]      load_data;
    logic             req_any;
    logic             req_bad;
    logic             tmo_hit;

    assign req_any = mem_read | mem_write;
    assign req_bad = is_misaligned(width_in, addr_in[2:0]);

    // Hold the pipeline from the cycle the request is seen until DONE.
    assign stall_out = (state == S_REQ) || (state == S_WAIT) ||
                       ((state == S_IDLE) && req_any && !req_bad);

    assign bus_req_valid = (state == S_REQ);

    // tmo_cnt counts REQ+WAIT cycles from 0, so the TIMEOUT-th cycle is the last.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    load_formatter u_load_formatter (
        .bus_rdata (bus_rdata),
        .lane      (lane_q),
        .width     (width_q),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rdata_out    <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            bus_addr     <= '0;
            bus_we       <= 1'b0;
            bus_wstrb    <= '0;
            bus_wdata    <= '0;
            width_q      <= '0;
            lane_q       <= '0;
            tmo_cnt      <= '0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        if (req_bad) begin
                            misalign_err <= 1'b1;
                        end else begin
                            bus_addr  <= {addr_in[63:3], 3'b000};
                            bus_we    <= mem_write;
                            bus_wstrb <= strobe_for(width_in, addr_in[2:0]);
                            bus_wdata <= wdata_in << {addr_in[2:0], 3'b000};
                            width_q   <= width_in;
                            lane_q    <= addr_in[2:0];
                            tmo_cnt   <= '0;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Timeout wins over a same-cycle handshake: the bridge
                    // abandons the transaction and any later response is stale.
                    if (tmo_hit) begin
                        bus_err <= 1'b1;
                        if (!bus_we) rdata_out <= '0;
                        state <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (bus_req_ready) state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response in the final allowed cycle still completes normally.
                    if (bus_resp_valid) begin
                        if (!bus_we) rdata_out <= load_data;
                        state <= S_DONE;
                    end else if (tmo_hit) begin
                        bus_err <= 1'b1;
                        if (!bus_we) rdata_out <= '0;
                        state <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
// Randomized and directed stimulus for dmem_bridge, checked against a
// byte-level reference model of the access rules.
module tb_dmem_bridge;

    localparam int TB_TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] addr_in;
    logic [63:0] wdata_in;
    logic [2:0]  width_in;
    logic [63:0] rdata_out;
    logic        stall_out;
    logic        misalign_err;
    logic        bus_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [63:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_wstrb;
    logic [63:0] bus_wdata;
    logic        bus_resp_valid;
    logic [63:0] bus_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] rdata_model = '0;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT(TB_TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .addr_in        (addr_in),
        .wdata_in       (wdata_in),
        .width_in       (width_in),
        .rdata_out      (rdata_out),
        .stall_out      (stall_out),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_addr       (bus_addr),
        .bus_we         (bus_we),
        .bus_wstrb      (bus_wstrb),
        .bus_wdata      (bus_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_rdata      (bus_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---- reference model ----
    function automatic int size_of(input logic [2:0] w);
        return 1 << w[1:0];
    endfunction

    function automatic bit is_legal(input logic [2:0] w, input logic [2:0] a);
        return (w != 3'b111) && ((int'(a) % size_of(w)) == 0);
    endfunction

    function automatic logic [7:0] model_strb(input logic [2:0] w, input logic [2:0] a);
        logic [7:0] s = '0;
        for (int i = 0; i < size_of(w); i++) s[int'(a) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [2:0] a);
        logic [63:0] r = '0;
        for (int i = 0; i + int'(a) < 8; i++) r[8*(int'(a)+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] bus, input logic [2:0] a,
                                               input logic [2:0] w);
        logic [63:0] r = '0;
        int nb = size_of(w);
        for (int i = 0; i < nb; i++) r[8*i +: 8] = bus[8*(int'(a)+i) +: 8];
        if (!w[2] && nb < 8 && r[8*nb-1])
            for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    // One complete MEM-stage access with the given bus delays.
    task automatic run_op(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [2:0] w, input logic [63:0] rd,
                          input int rdy_dly, input int rsp_dly);
        logic [2:0] a;
        bit         legal;
        int         stalls;
        a      = addr[2:0];
        legal  = is_legal(w, a);
        mem_write = wr;
        mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        addr_in   = addr;
        wdata_in  = wd;
        width_in  = w;
        #1;
        check("idle_stall", 64'(stall_out), 64'(legal));
        stalls = int'(stall_out);
        step();
        if (!legal) begin
            check("misalign_pulse", 64'(misalign_err), 64'd1);
            check("misalign_noreq", 64'(bus_req_valid), 64'd0);
            check("misalign_nostall", 64'(stall_out), 64'd0);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            step();
            check("misalign_clear", 64'(misalign_err), 64'd0);
            check("misalign_rdata", rdata_out, rdata_model);
            return;
        end
        check("legal_noerr", 64'(misalign_err), 64'd0);
        for (int c = 0; c <= rdy_dly; c++) begin
            check("req_valid", 64'(bus_req_valid), 64'd1);
            check("req_addr", bus_addr, addr & ~64'h7);
            check("req_we", 64'(bus_we), 64'(wr));
            if (wr) begin
                check("req_wstrb", 64'(bus_wstrb), 64'(model_strb(w, a)));
                check("req_wdata", bus_wdata, model_wdata(wd, a));
            end
            stalls += int'(stall_out);
            bus_req_ready  = (c == rdy_dly);
            bus_resp_valid = 1'($urandom_range(0, 1));   // stale, must be ignored
            bus_rdata      = {$urandom, $urandom};
            step();
        end
        bus_req_ready = 1'b0;
        for (int c = 0; c <= rsp_dly; c++) begin
            check("wait_novalid", 64'(bus_req_valid), 64'd0);
            stalls += int'(stall_out);
            bus_resp_valid = (c == rsp_dly);
            bus_rdata      = (c == rsp_dly) ? rd : {$urandom, $urandom};
            step();
        end
        bus_resp_valid = 1'b0;
        bus_rdata      = {$urandom, $urandom};
        if (!wr) rdata_model = model_load(rd, a, w);
        check("done_stall", 64'(stall_out), 64'd0);
        check("done_buserr", 64'(bus_err), 64'd0);
        check("done_rdata", rdata_out, rdata_model);
        check("stall_cycles", 64'(stalls), 64'(3 + rdy_dly + rsp_dly));
        mem_read  = 1'b0;
        mem_write = 1'b0;
        step();
        check("after_idle_stall", 64'(stall_out), 64'd0);
        check("after_idle_valid", 64'(bus_req_valid), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        addr_in = '0; wdata_in = '0; width_in = '0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;
        step();
        step();
        check("rst_rdata", rdata_out, 64'd0);
        check("rst_stall", 64'(stall_out), 64'd0);
        check("rst_valid", 64'(bus_req_valid), 64'd0);
        check("rst_we", 64'(bus_we), 64'd0);
        check("rst_wstrb", 64'(bus_wstrb), 64'd0);
        check("rst_addr", bus_addr, 64'd0);
        check("rst_wdata", bus_wdata, 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);
        check("rst_buserr", 64'(bus_err), 64'd0);
        rst = 1'b0;
        step();

        // directed: lb, sh, misaligned lw, delayed ld
        run_op(1'b0, 64'h1003, 64'd0, 3'b000, 64'h0000_0000_8000_0000, 0, 0);
        check("lb_value", rdata_out, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1'b1, 64'h2006, 64'hBEEF, 3'b001, 64'd0, 0, 0);
        run_op(1'b0, 64'h3002, 64'd0, 3'b010, 64'd0, 0, 0);
        run_op(1'b0, 64'h4000, 64'd0, 3'b011, 64'h0123_4567_89AB_CDEF, 3, 2);
        check("ld_value", rdata_out, 64'h0123_4567_89AB_CDEF);

        // random accesses
        for (int i = 0; i < 60; i++) begin
            logic [63:0] ad;
            logic [2:0]  w;
            int          rdy;
            ad  = {$urandom, $urandom};
            w   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0 && w != 3'b111) ad[2:0] = ad[2:0] & ~3'(size_of(w) - 1);
            rdy = $urandom_range(0, 3);
            run_op(1'($urandom_range(0, 1)), ad, {$urandom, $urandom}, w,
                   {$urandom, $urandom}, rdy, $urandom_range(0, 5 - rdy));
        end

        // make rdata_out nonzero before the timeout test
        run_op(1'b0, 64'h5000, 64'd0, 3'b011, 64'hCAFE_F00D_1234_5678, 0, 0);

        // timeout: handshake accepted, no response ever comes
        mem_read = 1'b1; addr_in = 64'h40; width_in = 3'b010;
        step();
        n = 0;
        while (stall_out && n < 30) begin
            bus_req_ready = (n == 1);
            step();
            n++;
        end
        bus_req_ready = 1'b0;
        rdata_model   = '0;
        check("tmo_cycles", 64'(n), 64'(TB_TMO));
        check("tmo_buserr", 64'(bus_err), 64'd1);
        check("tmo_rdata", rdata_out, 64'd0);
        check("tmo_novalid", 64'(bus_req_valid), 64'd0);
        mem_read = 1'b0;
        step();
        check("tmo_buserr_clear", 64'(bus_err), 64'd0);
        step();
        step();
        bus_resp_valid = 1'b1; bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        bus_resp_valid = 1'b0;
        check("late_resp_ignored", rdata_out, 64'd0);
        check("late_resp_nostall", 64'(stall_out), 64'd0);

        // reset while waiting for a response
        run_op(1'b0, 64'h6000, 64'd0, 3'b011, 64'h1111_2222_3333_4444, 0, 0);
        mem_read = 1'b1; addr_in = 64'h80; width_in = 3'b011;
        step();
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        check("pre_rst_stall", 64'(stall_out), 64'd1);
        rst = 1'b1; mem_read = 1'b0;
        step();
        rst = 1'b0;
        rdata_model = '0;
        check("rst_wait_valid", 64'(bus_req_valid), 64'd0);
        check("rst_wait_stall", 64'(stall_out), 64'd0);
        bus_resp_valid = 1'b1; bus_rdata = 64'h5555_6666_7777_8888;
        step();
        bus_resp_valid = 1'b0;
        check("rst_resp_discard", rdata_out, 64'd0);
        run_op(1'b0, 64'h7001, 64'd0, 3'b100, 64'h0000_0000_0000_9A00, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
